updown_counter_mod: RTL
=======================

// Module: updown_counter_mod
// PURPOSE
// - Parametrised modulo-N up/down counter with parallel load, sync clear, wrap/saturate mode, cascade carry.
// - Next-generation lab counter: drives the existing seg7 display path (one instance per digit) and
//   chains into multi-digit counters via cnt_en/co (e.g. MOD=10 for BCD decades).
// PARAMETERS
// - WIDTH      4       count register width in bits (1..16)
// - MOD        16      modulus; count range 0..MOD-1; require 2 <= MOD <= 2**WIDTH
// - RESET_VAL  0       value loaded by async reset and by sync clear; require RESET_VAL < MOD
// - SATURATE   0       0 = wrap at range ends; 1 = hold at range ends
// PORTS
// - clk       in   1      rising-edge clock
// - clr_n     in   1      asynchronous active-low reset
// - clr       in   1      synchronous clear, active-high
// - ld        in   1      synchronous parallel load, active-high
// - ld_val    in   WIDTH  load data, active-high
// - cnt_en    in   1      count enable (cascade input), active-high
// - dir       in   1      1 = up, 0 = down
// - count     out  WIDTH  registered count value
// - tc        out  1      terminal count, combinational: (dir & count==MOD-1) | (~dir & count==0)
// - co        out  1      cascade carry/borrow = tc & cnt_en; wire to next stage's cnt_en
// - wrapped   out  1      registered one-cycle pulse, high the cycle after a wrap transition
// BEHAVIOUR
// - clr_n low: count=RESET_VAL and wrapped=0 immediately, independent of clk.
//   First rising edge after deassertion acts normally.
// - All other updates on rising clk. Priority per edge: clr > ld > count. Exactly one action per edge.
// - clr: count <= RESET_VAL; wrapped <= 0.
// - ld: count <= ld_val if ld_val < MOD, else count <= MOD-1 (clamp); wrapped <= 0. ld overrides cnt_en.
// - Count with cnt_en=1:
//   - dir=1: count < MOD-1 -> count+1. count == MOD-1 -> 0 (SATURATE=0, wrapped<=1) or hold (SATURATE=1).
//   - dir=0: count > 0 -> count-1. count == 0 -> MOD-1 (SATURATE=0, wrapped<=1) or hold (SATURATE=1).
// - cnt_en=0 with no clr/ld: count holds; wrapped <= 0.
// - Latency: count reflects an action one edge after the inputs are sampled.
//   tc/co follow count and dir combinationally in the same cycle.
// - dir may change on any cycle. tc/co re-evaluate immediately. No glitch requirement beyond zero-delay sim.
// - Arithmetic: next value computed in WIDTH+1 bits; the compare against MOD precedes truncation.
//   No out-of-range value (>= MOD) is ever stored.
// - SATURATE=1: wrapped is constant 0. co still asserts at the range end, so the cascade stays usable.
// - Reset mid-operation: async clr_n overrides any in-flight clr/ld/count on that cycle.
// STRUCTURE
// - Shared package updown_pkg: localparams UD_DIR_UP=1'b1, UD_DIR_DOWN=1'b0, UD_MODE_WRAP=0, UD_MODE_SAT=1.
//   Also a function ud_clamp(val, mod) reused by the display counters.
// - One sub-module updown_next_val (combinational): inputs count, dir, cnt_en; outputs next count and a
//   wrap flag. The parent holds only the registers, priority mux, tc/co and parameter checks.
// - Elaboration check: illegal MOD/RESET_VAL/WIDTH combinations stop simulation with $error in an initial block.
// - Display stays external: count[3:0] feeds the existing seg7 decoder at the board top.
// TESTING (WIDTH=4, MOD=10, RESET_VAL=0 unless noted)
// - Async reset: clr_n=0 mid-count at count=7, between edges -> count=0 and wrapped=0 before the next edge.
// - Up wrap: cnt_en=1, dir=1 from 8 -> sequence 9,0,1. tc=1 while count=9. wrapped=1 exactly one cycle after the 9->0 edge.
// - Down wrap with SATURATE=1: dir=0 from 1 -> 0,0,0. tc=1 and co=1 at count=0. wrapped stays 0.
// - Priority: clr=1, ld=1, ld_val=5, cnt_en=1 on the same edge -> count=0. Then ld=1, cnt_en=1, ld_val=5 -> count=5.
// - Load clamp: ld_val=4'hC -> count=9. ld_val=3 -> count=3.
// - Cascade: two instances, co0 -> cnt_en1, both dir=1, from 09 for 2 edges -> 10 then 11.
//   co0 high only while digit0 is 9.

Source files
------------

// File: rtl/updown_pkg.sv
// updown_pkg: shared constants and helpers for the up/down counter family.
//   UD_DIR_UP / UD_DIR_DOWN : encoding of the dir input
//   UD_MODE_WRAP / UD_MODE_SAT : values of the SATURATE parameter
//   ud_clamp(val, mod) : returns val when val < mod, otherwise mod-1
package updown_pkg;

  localparam logic UD_DIR_UP    = 1'b1;
  localparam logic UD_DIR_DOWN  = 1'b0;
  localparam int   UD_MODE_WRAP = 0;
  localparam int   UD_MODE_SAT  = 1;

  // 17 bits covers the widest counter (16 bits) plus the modulus 2**16.
  function automatic logic [16:0] ud_clamp(input logic [16:0] val, input logic [16:0] mod);
    if (val < mod) return val;
    else           return mod - 17'd1;
  endfunction

endpackage

// File: rtl/updown_next_val.sv
// updown_next_val: combinational next-count computation for one counter digit.
//   count_i  : current registered count (always < MOD)
//   dir_i    : 1 = up, 0 = down
//   cnt_en_i : count enable
//   next_o   : count value for the next edge when no clear/load is active
//   wrap_o   : high when next_o is the result of a range-end wrap
module updown_next_val
  import updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             cnt_en_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

  // One extra bit so MOD = 2**WIDTH compares correctly and a decrement
  // from zero shows up as a borrow in the top bit.
  logic [WIDTH:0] up_w;
  logic [WIDTH:0] dn_w;

  assign up_w = {1'b0, count_i} + (WIDTH+1)'(1);
  assign dn_w = {1'b0, count_i} - (WIDTH+1)'(1);

  always_comb begin
    next_o = count_i;
    wrap_o = 1'b0;
    if (cnt_en_i) begin
      if (dir_i == UD_DIR_UP) begin
        if (up_w < MOD_W) begin
          next_o = up_w[WIDTH-1:0];
        end else if (SATURATE == UD_MODE_WRAP) begin
          next_o = '0;
          wrap_o = 1'b1;
        end
      end else begin
        if (!dn_w[WIDTH]) begin
          next_o = dn_w[WIDTH-1:0];
        end else if (SATURATE == UD_MODE_WRAP) begin
          next_o = TOP;
          wrap_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo-MOD up/down counter with parallel load, sync
// clear, wrap/saturate mode and cascade carry. One instance per display digit.
//   clk     : rising-edge clock
//   clr_n   : asynchronous active-low reset (count=RESET_VAL, wrapped=0)
//   clr     : synchronous clear (highest priority)
//   ld      : synchronous parallel load, clamped to MOD-1
//   ld_val  : load data
//   cnt_en  : count enable / cascade input
//   dir     : 1 = up, 0 = down
//   count   : registered count value
//   tc      : terminal count for the current direction (combinational)
//   co      : tc & cnt_en, feeds the next digit's cnt_en
//   wrapped : one-cycle pulse the cycle after a wrap transition
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             cnt_en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             co,
  output logic             wrapped
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be 1..16");
  end
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("updown_counter_mod: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_reset
    $error("updown_counter_mod: RESET_VAL must be below MOD");
  end
  if (SATURATE != UD_MODE_WRAP && SATURATE != UD_MODE_SAT) begin : g_bad_mode
    $error("updown_counter_mod: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  updown_next_val #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i  (count_q),
    .dir_i    (dir),
    .cnt_en_i (cnt_en),
    .next_o   (step_val),
    .wrap_o   (step_wrap)
  );

  always_comb begin
    count_d   = step_val;
    wrapped_d = step_wrap;
    if (clr) begin
      count_d   = RST;
      wrapped_d = 1'b0;
    end else if (ld) begin
      count_d   = WIDTH'(ud_clamp(17'(ld_val), 17'(MOD)));
      wrapped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q   <= RST;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign tc      = ((dir == UD_DIR_UP)   && (count_q == TOP)) ||
                   ((dir == UD_DIR_DOWN) && (count_q == '0));
  assign co      = tc & cnt_en;

endmodule
